xbar_alloc: RTL and testbench

XBAR_ALLOC -- requirements
Module: xbar_alloc

---
 rtl/xbar_pkg.sv | 15 +
 rtl/xbar_rr_arb.sv | 144 ++++++++++++++
 rtl/xbar_alloc.sv | 51 +++++
 tb/tb_xbar_alloc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared constants and types for the credit-based crossbar allocator.
package xbar_pkg;

  localparam int NPORTS  = 5;
  localparam int PORT_W  = 3;
  localparam int CREDITS = 4;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  // Per-output allocation state: IDLE arbitrates, LOCKED follows one packet owner.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xbar_rr_arb.sv
// One output port of the crossbar: round-robin arbiter, wormhole packet lock
// and downstream credit counter. Grant outputs are combinational so a flit
// moves in the same cycle it is selected.
module xbar_rr_arb
  import xbar_pkg::*;
#(
  parameter int NPORTS  = xbar_pkg::NPORTS,
  parameter int CREDITS = xbar_pkg::CREDITS,
  parameter int OUT_IDX = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        i_req_valid,
  input  logic [NPORTS*PORT_W-1:0] i_req_dest,
  input  logic [NPORTS-1:0]        i_req_tail,
  input  logic                     i_credit_ret,
  output logic [NPORTS-1:0]        o_gnt,
  output logic [PORT_W-1:0]        o_sel,
  output logic                     o_valid,
  output logic                     o_credit_err
);

  localparam int LCNT_W = $clog2(CREDITS + 1);

  arb_state_e          r_state;
  logic [PORT_W-1:0]   r_owner;
  logic [PORT_W-1:0]   r_rr_ptr;
  logic [LCNT_W-1:0]   r_credit;
  logic                r_credit_err;

  logic [NPORTS-1:0]   w_match;
  logic [2*NPORTS-1:0] w_rot;
  int                  w_off;
  int                  w_sum;
  logic                w_found_rr;
  logic [PORT_W-1:0]   w_rr_win;
  logic                w_own_hit;
  logic                w_found;
  logic [PORT_W-1:0]   w_win;
  logic                w_win_tail;
  logic                w_grant;
  logic [PORT_W-1:0]   w_next;

  // Decode which inputs target this output; out-of-range destinations never match.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_match[i] = i_req_valid[i] &&
                   (i_req_dest[i*PORT_W +: PORT_W] == PORT_W'(OUT_IDX));
    end
  end

  // Round-robin search: rotate requests so rr_ptr sits at bit 0, take lowest set bit.
  always_comb begin
    w_rot      = {w_match, w_match} >> r_rr_ptr;
    w_found_rr = |w_rot[NPORTS-1:0];
    w_off      = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? k : w_off;
    end
    w_sum    = int'(r_rr_ptr) + w_off;
    w_rr_win = PORT_W'((w_sum >= NPORTS) ? (w_sum - NPORTS) : w_sum);
  end

  // Locked output listens only to the owner of the packet in flight.
  always_comb begin
    w_own_hit = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      w_own_hit = (PORT_W'(i) == r_owner) ? w_match[i] : w_own_hit;
    end
  end

  // Select winner by state, gate on credit and reset, and form the grant outputs.
  always_comb begin
    case (r_state)
      IDLE: begin
        w_found = w_found_rr;
        w_win   = w_rr_win;
      end
      LOCKED: begin
        w_found = w_own_hit;
        w_win   = r_owner;
      end
      default: begin
        w_found = 1'b0;
        w_win   = '0;
      end
    endcase
    w_grant    = w_found && (r_credit != '0) && !rst;
    w_win_tail = 1'b0;
    o_gnt      = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_win_tail = (PORT_W'(i) == w_win) ? i_req_tail[i] : w_win_tail;
      o_gnt[i]   = w_grant && (PORT_W'(i) == w_win);
    end
    o_valid = w_grant;
    o_sel   = w_grant ? w_win : '0;
    w_next  = (w_win == PORT_W'(NPORTS - 1)) ? '0 : (w_win + PORT_W'(1));
  end

  // Credit bookkeeping: a grant consumes a slot, a return frees one, both cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit     <= LCNT_W'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      if (w_grant && !i_credit_ret) begin
        r_credit <= r_credit - LCNT_W'(1);
      end else if (!w_grant && i_credit_ret) begin
        if (r_credit == LCNT_W'(CREDITS)) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credit <= r_credit + LCNT_W'(1);
        end
      end else begin
        r_credit <= r_credit;
      end
    end
  end

  // Packet lock FSM: head locks the output, tail releases it and advances rr_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      if (w_win_tail) begin
        r_state  <= IDLE;
        r_rr_ptr <= w_next;
      end else if (r_state == IDLE) begin
        r_state <= LOCKED;
        r_owner <= w_win;
      end else begin
        r_state <= r_state;
      end
    end else begin
      r_state <= r_state;
    end
  end

  assign o_credit_err = r_credit_err;

endmodule

// File: rtl/xbar_alloc.sv
// Crossbar switch allocator: one round-robin/credit arbiter per output;
// input grants are the OR of the per-output one-hot grant vectors, which
// never overlap because each input names a single destination.
module xbar_alloc
  import xbar_pkg::*;
#(
  parameter int NPORTS  = xbar_pkg::NPORTS,
  parameter int CREDITS = xbar_pkg::CREDITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS*PORT_W-1:0] req_dest,
  input  logic [NPORTS-1:0]        req_tail,
  input  logic [NPORTS-1:0]        credit_ret,
  output logic [NPORTS-1:0]        gnt,
  output logic [NPORTS*PORT_W-1:0] xbar_sel,
  output logic [NPORTS-1:0]        xbar_valid,
  output logic [NPORTS-1:0]        credit_err
);

  logic [NPORTS-1:0] w_gnt_vec [NPORTS];

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    xbar_rr_arb #(
      .NPORTS  (NPORTS),
      .CREDITS (CREDITS),
      .OUT_IDX (o)
    ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (req_valid),
      .i_req_dest   (req_dest),
      .i_req_tail   (req_tail),
      .i_credit_ret (credit_ret[o]),
      .o_gnt        (w_gnt_vec[o]),
      .o_sel        (xbar_sel[o*PORT_W +: PORT_W]),
      .o_valid      (xbar_valid[o]),
      .o_credit_err (credit_err[o])
    );
  end

  // Merge per-output grant vectors into the per-input grant.
  always_comb begin
    gnt = '0;
    for (int o = 0; o < NPORTS; o++) begin
      gnt = gnt | w_gnt_vec[o];
    end
  end

endmodule

// File: tb/tb_xbar_alloc.sv
// Directed scoreboard bench for xbar_alloc (NPORTS=5, CREDITS=4).
module tb_xbar_alloc;

  logic        clk;
  logic        rst;
  logic [4:0]  req_valid;
  logic [14:0] req_dest;
  logic [4:0]  req_tail;
  logic [4:0]  credit_ret;
  logic [4:0]  gnt;
  logic [14:0] xbar_sel;
  logic [4:0]  xbar_valid;
  logic [4:0]  credit_err;

  typedef struct {
    string       name;
    logic [4:0]  g;
    logic [4:0]  v;
    logic [14:0] s;
    logic [4:0]  e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  xbar_alloc #(.NPORTS(5), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dest   (req_dest),
    .req_tail   (req_tail),
    .credit_ret (credit_ret),
    .gnt        (gnt),
    .xbar_sel   (xbar_sel),
    .xbar_valid (xbar_valid),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack five 3-bit fields, field 0 in the least significant position.
  function automatic logic [14:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4);
    pk = {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Drive one cycle of stimulus and queue the response it must produce.
  task automatic cyc(input string nm, input logic r, input logic [4:0] v,
                     input logic [14:0] d, input logic [4:0] t, input logic [4:0] c,
                     input logic [4:0] eg, input logic [4:0] ev,
                     input logic [14:0] es, input logic [4:0] ee);
    exp_t x;
    @(posedge clk);
    #1;
    rst        = r;
    req_valid  = v;
    req_dest   = d;
    req_tail   = t;
    credit_ret = c;
    x.name = nm; x.g = eg; x.v = ev; x.s = es; x.e = ee;
    q.push_back(x);
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (gnt !== x.g) begin
        errors++;
        $display("FAIL %s gnt: got %b expected %b", x.name, gnt, x.g);
      end
      checks++;
      if (xbar_valid !== x.v) begin
        errors++;
        $display("FAIL %s xbar_valid: got %b expected %b", x.name, xbar_valid, x.v);
      end
      checks++;
      if (xbar_sel !== x.s) begin
        errors++;
        $display("FAIL %s xbar_sel: got %h expected %h", x.name, xbar_sel, x.s);
      end
      checks++;
      if (credit_err !== x.e) begin
        errors++;
        $display("FAIL %s credit_err: got %b expected %b", x.name, credit_err, x.e);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 5'b00000;
    req_dest   = 15'h0000;
    req_tail   = 5'b00000;
    credit_ret = 5'b00000;

    // Reset forces outputs low even with a pending request.
    cyc("rst_req",  1'b1, 5'b00001, pk(0,0,0,0,0), 5'b00001, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    cyc("rst_idle", 1'b1, 5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);

    // Single flit input 2 -> output 3.
    cyc("single",   1'b0, 5'b00100, pk(0,0,3,0,0), 5'b00100, 5'b00000, 5'b00100, 5'b01000, pk(0,0,0,2,0), 5'b00000);
    cyc("quiet",    1'b0, 5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);

    // Round robin on output 1 among inputs 0, 1, 4; then rr_ptr back at 0.
    cyc("rr_0",     1'b0, 5'b10011, pk(1,1,0,0,1), 5'b10011, 5'b00000, 5'b00001, 5'b00010, pk(0,0,0,0,0), 5'b00000);
    cyc("rr_1",     1'b0, 5'b10010, pk(0,1,0,0,1), 5'b10010, 5'b00000, 5'b00010, 5'b00010, pk(0,1,0,0,0), 5'b00000);
    cyc("rr_4",     1'b0, 5'b10000, pk(0,0,0,0,1), 5'b10000, 5'b00000, 5'b10000, 5'b00010, pk(0,4,0,0,0), 5'b00000);
    cyc("rr_wrap",  1'b0, 5'b10001, pk(1,0,0,0,1), 5'b10001, 5'b00000, 5'b00001, 5'b00010, pk(0,0,0,0,0), 5'b00000);

    // 3-flit packet from input 1 to output 0 with input 3 contending.
    cyc("pkt_head", 1'b0, 5'b01010, pk(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00010, 5'b00001, pk(1,0,0,0,0), 5'b00000);
    cyc("pkt_lock", 1'b0, 5'b01000, pk(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    cyc("pkt_body", 1'b0, 5'b01010, pk(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00010, 5'b00001, pk(1,0,0,0,0), 5'b00000);
    cyc("pkt_tail", 1'b0, 5'b01010, pk(0,0,0,0,0), 5'b01010, 5'b00000, 5'b00010, 5'b00001, pk(1,0,0,0,0), 5'b00000);
    // Input 3 next; its grant coincides with a credit return (credit stays 1).
    cyc("in3_ret",  1'b0, 5'b01000, pk(0,0,0,0,0), 5'b01000, 5'b00001, 5'b01000, 5'b00001, pk(3,0,0,0,0), 5'b00000);
    cyc("in3_last", 1'b0, 5'b01000, pk(0,0,0,0,0), 5'b01000, 5'b00000, 5'b01000, 5'b00001, pk(3,0,0,0,0), 5'b00000);
    cyc("out0_dry", 1'b0, 5'b01000, pk(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);

    // Six flits to output 2: four grants, stall, one return, one more grant.
    for (int n = 0; n < 4; n++) begin
      cyc("cred_gnt", 1'b0, 5'b00001, pk(2,0,0,0,0), 5'b00001, 5'b00000, 5'b00001, 5'b00100, pk(0,0,0,0,0), 5'b00000);
    end
    cyc("stall_a",  1'b0, 5'b00001, pk(2,0,0,0,0), 5'b00001, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    cyc("stall_b",  1'b0, 5'b00001, pk(2,0,0,0,0), 5'b00001, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    cyc("ret_cyc",  1'b0, 5'b00001, pk(2,0,0,0,0), 5'b00001, 5'b00100, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    cyc("ret_gnt",  1'b0, 5'b00001, pk(2,0,0,0,0), 5'b00001, 5'b00000, 5'b00001, 5'b00100, pk(0,0,0,0,0), 5'b00000);
    cyc("stall_c",  1'b0, 5'b00001, pk(2,0,0,0,0), 5'b00001, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);

    // Overflow return on full output 4 (sticky error), legal return on output 3.
    cyc("ovf_ret",  1'b0, 5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b11000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    for (int n = 0; n < 4; n++) begin
      cyc("out4_gnt", 1'b0, 5'b00010, pk(0,4,0,0,0), 5'b00010, 5'b00000, 5'b00010, 5'b10000, pk(0,0,0,0,1), 5'b10000);
    end
    cyc("out4_dry", 1'b0, 5'b00010, pk(0,4,0,0,0), 5'b00010, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b10000);

    // Head of a packet locks output 3 to input 0, then reset mid-packet.
    cyc("lk_head",  1'b0, 5'b00001, pk(3,0,0,0,0), 5'b00000, 5'b00000, 5'b00001, 5'b01000, pk(0,0,0,0,0), 5'b10000);
    cyc("mid_rst",  1'b1, 5'b00101, pk(3,0,3,0,0), 5'b00100, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    cyc("post_rst", 1'b0, 5'b00100, pk(0,0,3,0,0), 5'b00100, 5'b00000, 5'b00100, 5'b01000, pk(0,0,0,2,0), 5'b00000);

    // Out-of-range destinations are ignored.
    cyc("bad_dest", 1'b0, 5'b00110, pk(0,5,7,0,0), 5'b00110, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);
    // Independent grants on outputs 0, 1 and 4 in one cycle.
    cyc("parallel", 1'b0, 5'b01111, pk(0,1,6,4,0), 5'b01111, 5'b00000, 5'b01011, 5'b10011, pk(0,1,0,0,3), 5'b00000);
    cyc("tail_off", 1'b0, 5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b00000);

    // Let the monitor drain the queue, bounded.
    for (int w = 0; w < 10 && q.size() > 0; w++) begin
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
